// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI follower.
package spi_pkg;
    localparam int LEN_8           = 8;
    localparam int LEN_16          = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    // MSB-first shifting always starts at bit 15, so 8-bit words sit in the top byte.
    function automatic logic [15:0] tx_align(input logic [15:0] w, input logic len16);
        return len16 ? w : {w[7:0], 8'h00};
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-bit synchronizer with registered rise/fall pulses on bit 0.
module spi_sync_edge #(
    parameter int           STAGES  = 2,
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_sync,
    output logic         o_rise,
    output logic         o_fall
);
    logic [STAGES-1:0][W-1:0] r_sync;
    logic                     r_rise;
    logic                     r_fall;

    // Pulses are taken one stage early so they line up with the new o_sync value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_rise <= r_sync[STAGES-2][0] & ~r_sync[STAGES-1][0];
            r_fall <= ~r_sync[STAGES-2][0] & r_sync[STAGES-1][0];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_rise;
    assign o_fall = r_fall;
endmodule

// File: rtl/spi_follower.sv
// SPI follower: modes 0-3, 8/16-bit frames, one-entry TX/RX buffers, sticky error flags.
module spi_follower
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpol,
    input  logic        i_cpha,
    input  logic        i_len,
    input  logic        i_ext_clk,
    input  logic        i_cs,
    input  logic        i_serial_in,
    output logic        o_serial_out,
    output logic        o_serial_oe,
    input  logic [15:0] i_tx_data,
    input  logic        i_tx_valid,
    output logic        o_tx_ready,
    output logic [15:0] o_rx_data,
    output logic        o_rx_valid,
    input  logic        i_rx_ready,
    output logic        o_overrun,
    output logic        o_underrun,
    output logic        o_frame_abort,
    input  logic        i_clr_status
);
    logic [2:0]  w_sync;
    logic        w_rise, w_fall, w_cs, w_sin;
    logic        w_lead, w_trail, w_sample, w_shift;
    logic        w_load, w_tx_wr;
    logic [4:0]  w_len_n, w_cnt_nx;
    logic [15:0] w_word;

    state_t      r_state;
    logic        r_cpol, r_cpha, r_len;
    logic [4:0]  r_cnt;
    logic [15:0] r_tx_sh, r_rx_sh, r_tx_buf, r_rx_data;
    logic        r_tx_full, r_rx_valid, r_so;
    logic        r_overrun, r_underrun, r_frame_abort;

    // Bit order {serial_in, cs, ext_clk}; cs resets high so the bus looks deselected.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .W(3), .RST_VAL(3'b010)) u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    ({i_serial_in, i_cs, i_ext_clk}),
        .o_sync (w_sync),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_cs     = w_sync[1];
    assign w_sin    = w_sync[2];
    assign w_lead   = r_cpol ? w_fall : w_rise;
    assign w_trail  = r_cpol ? w_rise : w_fall;
    assign w_sample = r_cpha ? w_trail : w_lead;
    assign w_shift  = r_cpha ? w_lead : w_trail;
    assign w_len_n  = r_len ? 5'(LEN_16) : 5'(LEN_8);
    assign w_cnt_nx = r_cnt + 5'd1;
    assign w_tx_wr  = i_tx_valid & ~r_tx_full;
    assign w_load   = ~w_cs & (r_state == IDLE || r_state == DONE);
    assign w_word   = tx_align(r_tx_full ? r_tx_buf : 16'hFFFF, i_len);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cpol        <= 1'b0;
            r_cpha        <= 1'b0;
            r_len         <= 1'b0;
            r_cnt         <= '0;
            r_tx_sh       <= '0;
            r_rx_sh       <= '0;
            r_tx_buf      <= '0;
            r_rx_data     <= '0;
            r_tx_full     <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_so          <= 1'b0;
            r_overrun     <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            // Clear first so any set later in this block wins.
            if (i_clr_status) begin
                r_overrun     <= 1'b0;
                r_underrun    <= 1'b0;
                r_frame_abort <= 1'b0;
            end
            if (r_rx_valid && i_rx_ready)
                r_rx_valid <= 1'b0;

            // A load takes the old buffer contents; a same-cycle write refills it.
            if (w_load) begin
                r_tx_full <= 1'b0;
                r_cpol    <= i_cpol;
                r_cpha    <= i_cpha;
                r_len     <= i_len;
                r_cnt     <= '0;
                r_rx_sh   <= '0;
                if (!r_tx_full)
                    r_underrun <= 1'b1;
                if (i_cpha) begin
                    r_tx_sh <= w_word;
                end else begin
                    r_so    <= w_word[15];
                    r_tx_sh <= {w_word[14:0], 1'b0};
                end
            end
            if (w_tx_wr) begin
                r_tx_buf  <= i_tx_data;
                r_tx_full <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (!w_cs)
                        r_state <= ACTIVE;
                end
                ACTIVE: begin
                    if (w_cs) begin
                        r_state <= IDLE;
                        // No bits taken means nothing partial to discard.
                        if (r_cnt != 5'd0)
                            r_frame_abort <= 1'b1;
                    end else begin
                        if (w_sample) begin
                            r_rx_sh <= {r_rx_sh[14:0], w_sin};
                            r_cnt   <= w_cnt_nx;
                            if (w_cnt_nx == w_len_n)
                                r_state <= DONE;
                        end
                        // With cpha=0 the trailing edge that ends the previous frame must not shift.
                        if (w_shift && (r_cpha || r_cnt != 5'd0)) begin
                            r_so    <= r_tx_sh[15];
                            r_tx_sh <= {r_tx_sh[14:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    r_rx_data  <= r_len ? r_rx_sh : {8'h00, r_rx_sh[7:0]};
                    r_rx_valid <= 1'b1;
                    if (r_rx_valid && !i_rx_ready)
                        r_overrun <= 1'b1;
                    r_state <= w_cs ? IDLE : ACTIVE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_serial_out  = r_so;
    assign o_serial_oe   = ~w_cs;
    assign o_tx_ready    = ~r_tx_full;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_overrun     = r_overrun;
    assign o_underrun    = r_underrun;
    assign o_frame_abort = r_frame_abort;
endmodule

// File: tb/tb_spi_follower.sv
// Directed bench for spi_follower: the bench plays the SPI leader at clk/16.
module tb_spi_follower;
    logic        clk = 1'b0;
    logic        rst, cpol, cpha, len, ext_clk, cs, sin, so, oe;
    logic [15:0] tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
    logic        overrun, underrun, frame_abort, clr_status;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    spi_follower dut (
        .i_clk(clk), .i_rst(rst), .i_cpol(cpol), .i_cpha(cpha), .i_len(len),
        .i_ext_clk(ext_clk), .i_cs(cs), .i_serial_in(sin),
        .o_serial_out(so), .o_serial_oe(oe),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
        .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
        .o_overrun(overrun), .o_underrun(underrun), .o_frame_abort(frame_abort),
        .i_clr_status(clr_status)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic p, input logic h, input logic l);
        @(negedge clk);
        cpol = p; cpha = h; len = l; ext_clk = p;
        wait_clk(8);
    endtask

    task automatic tx_write(input logic [15:0] d);
        @(negedge clk);
        tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic read_rx();
        @(negedge clk); rx_ready = 1'b1;
        @(negedge clk); rx_ready = 1'b0;
    endtask

    task automatic clear_flags();
        @(negedge clk); clr_status = 1'b1;
        @(negedge clk); clr_status = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk); cs = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_high();
        @(negedge clk); cs = 1'b1;
        wait_clk(8);
    endtask

    // Leader side of nbits bit-times; returns what it sampled on the follower's line.
    task automatic xfer(input logic [15:0] mosi, input int nbits, output logic [15:0] miso);
        miso = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                sin = mosi[nbits-1-i];
                wait_clk(8);
                miso = {miso[14:0], so};
                ext_clk = ~cpol;
                wait_clk(8);
                ext_clk = cpol;
            end else begin
                wait_clk(8);
                ext_clk = ~cpol;
                sin = mosi[nbits-1-i];
                wait_clk(8);
                miso = {miso[14:0], so};
                ext_clk = cpol;
            end
        end
        wait_clk(8);
    endtask

    // A spare word feeds the reload at frame end, which happens while cs is still low.
    task automatic single_frame(input logic p, input logic h, input logic l, input logic [15:0] tx,
                                input logic [15:0] mosi, output logic [15:0] miso);
        set_mode(p, h, l);
        tx_write(tx);
        cs_low();
        tx_write(16'h0000);
        xfer(mosi, l ? 16 : 8, miso);
        cs_high();
    endtask

    task automatic test_reset();
        wait_clk(3);
        n_checks++; if (so !== 1'b0 || oe !== 1'b0) begin n_fail++; $display("FAIL reset_pins got so=%b oe=%b exp 0 0", so, oe); end
        n_checks++; if (tx_ready !== 1'b1 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hs got tx_ready=%b rx_valid=%b exp 1 0", tx_ready, rx_valid); end
        n_checks++; if ({rx_data, overrun, underrun, frame_abort} !== 19'h0) begin n_fail++; $display("FAIL reset_data got rx=%h flags=%b%b%b exp 0", rx_data, overrun, underrun, frame_abort); end
        @(negedge clk); rst = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_mode0();
        logic [15:0] miso;
        single_frame(1'b0, 1'b0, 1'b0, 16'h00A5, 16'h003C, miso);
        n_checks++; if (miso !== 16'h00A5) begin n_fail++; $display("FAIL mode0_miso got=%h exp=00a5", miso); end
        n_checks++; if (rx_data !== 16'h003C || rx_valid !== 1'b1) begin n_fail++; $display("FAIL mode0_rx got=%h v=%b exp=003c v=1", rx_data, rx_valid); end
        n_checks++; if ({overrun, underrun, frame_abort} !== 3'b000) begin n_fail++; $display("FAIL mode0_flags got=%b%b%b exp=000", overrun, underrun, frame_abort); end
        read_rx();
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_read got rx_valid=%b exp 0", rx_valid); end
    endtask

    task automatic test_mode3();
        logic [15:0] miso;
        single_frame(1'b1, 1'b1, 1'b1, 16'h1234, 16'hBEEF, miso);
        n_checks++; if (miso !== 16'h1234) begin n_fail++; $display("FAIL mode3_miso got=%h exp=1234", miso); end
        n_checks++; if (rx_data !== 16'hBEEF || rx_valid !== 1'b1) begin n_fail++; $display("FAIL mode3_rx got=%h v=%b exp=beef v=1", rx_data, rx_valid); end
        read_rx();
    endtask

    task automatic test_back_to_back(input logic p, input logic h, input logic [15:0] w0, input logic [15:0] w1,
                                     input logic [15:0] m0, input logic [15:0] m1, input logic do_read);
        logic [15:0] a, b;
        set_mode(p, h, 1'b0);
        clear_flags();
        tx_write(w0);
        cs_low();
        tx_write(w1);
        xfer(m0, 8, a);
        if (do_read) begin
            n_checks++; if (rx_data !== m0) begin n_fail++; $display("FAIL b2b_first_rx mode=%b%b got=%h exp=%h", p, h, rx_data, m0); end
            read_rx();
        end
        xfer(m1, 8, b);
        cs_high();
        n_checks++; if (a !== w0 || b !== w1) begin n_fail++; $display("FAIL b2b_miso mode=%b%b got=%h,%h exp=%h,%h", p, h, a, b, w0, w1); end
        n_checks++; if (rx_data !== m1 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rx mode=%b%b got=%h v=%b exp=%h v=1", p, h, rx_data, rx_valid, m1); end
        n_checks++; if (overrun !== !do_read) begin n_fail++; $display("FAIL b2b_overrun mode=%b%b got=%b exp=%b", p, h, overrun, !do_read); end
        read_rx();
        clear_flags();
    endtask

    task automatic test_underrun();
        logic [15:0] miso;
        set_mode(1'b0, 1'b0, 1'b0);
        cs_low();
        xfer(16'h005A, 8, miso);
        cs_high();
        n_checks++; if (miso !== 16'h00FF) begin n_fail++; $display("FAIL underrun_miso got=%h exp=00ff", miso); end
        n_checks++; if (underrun !== 1'b1 || rx_data !== 16'h005A) begin n_fail++; $display("FAIL underrun_flag got=%b rx=%h exp=1 rx=005a", underrun, rx_data); end
        clear_flags();
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clr got=%b exp=0", underrun); end
        read_rx();
    endtask

    task automatic test_abort();
        logic [15:0] miso;
        single_frame(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0077, miso);
        clear_flags();
        tx_write(16'h000F);
        cs_low();
        xfer(16'h001F, 5, miso);
        cs_high();
        n_checks++; if (frame_abort !== 1'b1) begin n_fail++; $display("FAIL abort_flag got=%b exp=1", frame_abort); end
        n_checks++; if (rx_valid !== 1'b1 || rx_data !== 16'h0077) begin n_fail++; $display("FAIL abort_rx got=%h v=%b exp=0077 v=1", rx_data, rx_valid); end
        read_rx();
        clear_flags();
        single_frame(1'b0, 1'b0, 1'b0, 16'h0042, 16'h0024, miso);
        n_checks++; if (miso !== 16'h0042 || rx_data !== 16'h0024) begin n_fail++; $display("FAIL abort_next got miso=%h rx=%h exp 0042 0024", miso, rx_data); end
        n_checks++; if ({overrun, frame_abort} !== 2'b00) begin n_fail++; $display("FAIL abort_next_flags got=%b%b exp=00", overrun, frame_abort); end
        read_rx();
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] miso;
        set_mode(1'b0, 1'b0, 1'b0);
        tx_write(16'h0099);
        cs_low();
        xfer(16'h0005, 3, miso);
        @(negedge clk);
        rst = 1'b1; cs = 1'b1;
        #1;
        n_checks++; if (so !== 1'b0 || oe !== 1'b0 || tx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_pins got so=%b oe=%b tx_ready=%b exp 0 0 1", so, oe, tx_ready); end
        n_checks++; if ({rx_valid, rx_data, overrun, underrun, frame_abort} !== 20'h0) begin n_fail++; $display("FAIL midrst_state got v=%b rx=%h flags=%b%b%b exp 0", rx_valid, rx_data, overrun, underrun, frame_abort); end
        wait_clk(4);
        rst = 1'b0;
        wait_clk(8);
        single_frame(1'b0, 1'b0, 1'b0, 16'h0037, 16'h00C8, miso);
        n_checks++; if (miso !== 16'h0037 || rx_data !== 16'h00C8 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_next got miso=%h rx=%h v=%b exp 0037 00c8 1", miso, rx_data, rx_valid); end
        n_checks++; if ({overrun, underrun, frame_abort} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags got=%b%b%b exp=000", overrun, underrun, frame_abort); end
    endtask

    initial begin
        rst = 1'b1; cpol = 1'b0; cpha = 1'b0; len = 1'b0; ext_clk = 1'b0; cs = 1'b1; sin = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; clr_status = 1'b0;
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back(1'b0, 1'b1, 16'h0081, 16'h007E, 16'h000F, 16'h00F0, 1'b1);
        test_back_to_back(1'b1, 1'b0, 16'h005A, 16'h00C3, 16'h0096, 16'h0069, 1'b1);
        test_back_to_back(1'b0, 1'b1, 16'h0011, 16'h0022, 16'h00AA, 16'h0055, 1'b0);
        test_underrun();
        test_abort();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
